// File: rtl/loopback_checker.sv
// Stimulus/check end for a 32-bit pass-through path: sends an LFSR word stream,
// checks the returned stream in order, counts mismatches and detects a stalled return path.
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   SEND  | issuing words, checking returns
//   DRAIN | all words issued, waiting for the remaining returns
//   DONE  | run finished (normally or by timeout), waiting for start
module loopback_checker #(
   parameter int unsigned NUM_WORDS = 256,
   parameter int unsigned MAX_OUTST = 8,
   parameter int unsigned TIMEOUT   = 1024,
   parameter logic [31:0] SEED      = 32'hACE1_0001
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [31:0] tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [31:0] rx_data,
   input  logic        rx_valid,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic        timeout,
   output logic [15:0] mism_cnt
);

   localparam logic [31:0]   SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
   localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
   localparam logic [15:0]   NUM_W    = 16'(NUM_WORDS);
   localparam logic [7:0]    MAX_W    = 8'(MAX_OUTST);
   localparam logic [TW-1:0] TO_W     = TW'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, SEND, DRAIN, DONE} state_t;

   state_t        state;
   logic [31:0]   tx_lfsr;
   logic [31:0]   rx_lfsr;
   logic [15:0]   sent;
   logic [7:0]    outst;
   logic [TW-1:0] idle_cnt;

   logic        run;
   logic        tx_fire;
   logic        rx_hit;
   logic        rx_bad;
   logic        idle_trip;
   logic [15:0] mism_inc;

   function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
      return {cur[30:0], cur[31] ^ cur[21] ^ cur[1] ^ cur[0]};
   endfunction

   // tx_valid/tx_data depend only on registers, so they hold steady while the sink stalls
   always_comb begin
      run       = (state == SEND) || (state == DRAIN);
      tx_valid  = (state == SEND) && (sent < NUM_W) && (outst < MAX_W);
      tx_data   = tx_valid ? tx_lfsr : 32'h0;
      tx_fire   = tx_valid && tx_ready;
      rx_hit    = rx_valid && run && (outst != 8'd0);
      rx_bad    = rx_valid && (!rx_hit || (rx_data != rx_lfsr));
      idle_trip = run && !rx_valid && (outst != 8'd0) && ((idle_cnt + TW'(1)) == TO_W);
      mism_inc  = (mism_cnt == 16'hFFFF) ? mism_cnt : mism_cnt + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         tx_lfsr  <= SEED_EFF;
         rx_lfsr  <= SEED_EFF;
         sent     <= '0;
         outst    <= '0;
         idle_cnt <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
         timeout  <= 1'b0;
         mism_cnt <= '0;
      end else begin
         busy <= run;
         done <= (state == DONE);

         if (!run) begin
            if (start) begin
               state    <= SEND;
               tx_lfsr  <= SEED_EFF;
               rx_lfsr  <= SEED_EFF;
               sent     <= '0;
               outst    <= '0;
               done     <= 1'b0;
               error    <= 1'b0;
               timeout  <= 1'b0;
               mism_cnt <= '0;
            end else if (rx_valid) begin
               error    <= 1'b1;
               mism_cnt <= mism_inc;
            end
         end else begin
            if (tx_fire) begin
               tx_lfsr <= lfsr_step(tx_lfsr);
               sent    <= sent + 16'd1;
            end
            if (rx_hit)
               rx_lfsr <= lfsr_step(rx_lfsr);
            if (rx_bad) begin
               error    <= 1'b1;
               mism_cnt <= mism_inc;
            end
            case ({tx_fire, rx_hit})
               2'b10:   outst <= outst + 8'd1;
               2'b01:   outst <= outst - 8'd1;
               default: ;
            endcase

            if (idle_trip) begin
               state   <= DONE;
               timeout <= 1'b1;
               error   <= 1'b1;
            end else if ((state == SEND) && (sent == NUM_W)) begin
               state <= DRAIN;
            end else if ((state == DRAIN) && (outst == 8'd0)) begin
               state <= DONE;
            end
         end

         // idle timer only runs while words are owed back during a run
         if ((start && !run) || rx_valid || (outst == 8'd0))
            idle_cnt <= '0;
         else if (run)
            idle_cnt <= idle_cnt + TW'(1);
      end
   end

endmodule
